// File: rtl/conf_merge_n.sv
// conf_merge_n: merges N_IN pulse inputs into one delayed, fixed-width pulse
// stream while enforcing a minimum separation between input events.
// MODE 0 flags colliding events and routes them to out_err. MODE 1 queues
// colliding events and re-issues them one window apart.
module conf_merge_n #(
  parameter int N_IN    = 2,
  parameter int DELAY   = 15,
  parameter int T_SEP   = 10,
  parameter int PULSE_W = 2,
  parameter int MODE    = 0,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  localparam int PEND_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in_pulse,
  output logic              out,
  output logic              out_err,
  output logic              viol,
  output logic [N_IN-1:0]   viol_src,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [CNT_W-1:0]  last_time,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam int KW    = $clog2(N_IN + 1);
  localparam int SW    = $clog2(DEPTH + N_IN + 1);
  localparam int SEP_W = $clog2(T_SEP + 1);
  localparam int STR_W = $clog2(PULSE_W + 1);

  typedef struct packed {
    logic vld;
    logic err;
  } dl_ent_t;

  logic [N_IN-1:0]             prev_q, prev_d;
  logic [CNT_W-1:0]            ts_q, ts_d;
  logic [CNT_W-1:0]            last_time_q, last_time_d;
  logic [SEP_W-1:0]            sep_q, sep_d;
  logic [PEND_W-1:0]           pend_q, pend_d;
  logic                        ovf_q, ovf_d;
  logic                        viol_q, viol_d;
  logic [N_IN-1:0]             viol_src_q, viol_src_d;
  logic [CNT_W-1:0]            viol_cnt_q, viol_cnt_d;
  dl_ent_t [DELAY-1:0]         dl_q, dl_d;
  logic [STR_W-1:0]            str_v_q, str_v_d;
  logic [STR_W-1:0]            str_e_q, str_e_d;

  logic [N_IN-1:0] ev;
  logic [KW-1:0]   k;
  logic [SW-1:0]   sum;
  logic            win_open, restart, ins_v, ins_e, is_viol;

  // Event detection, window/queue arbitration, delay line and stretchers.
  always_comb begin
    ev       = in_pulse & ~prev_q;
    k        = '0;
    for (int i = 0; i < N_IN; i++) k = k + KW'(ev[i]);
    win_open = (sep_q != '0);
    restart  = 1'b0;
    ins_v    = 1'b0;
    ins_e    = 1'b0;
    is_viol  = 1'b0;
    sum      = '0;
    pend_d   = pend_q;
    ovf_d    = ovf_q;

    if (MODE == 0) begin
      // Any event restarts the window; only a lone event outside it is clean.
      if (k != '0) restart = 1'b1;
      if (k == KW'(1) && !win_open) ins_v = 1'b1;
      else if (k != '0) begin
        is_viol = 1'b1;
        ins_e   = 1'b1;
      end
    end else begin
      // Arrivals land first so a same-cycle issue can consume them.
      sum = SW'(pend_q) + SW'(k);
      if (sum > SW'(DEPTH)) begin
        is_viol = 1'b1;
        ovf_d   = 1'b1;
        sum     = SW'(DEPTH);
      end
      if (!win_open && sum != '0) begin
        sum     = sum - SW'(1);
        restart = 1'b1;
        ins_v   = 1'b1;
      end
      pend_d = PEND_W'(sum);
    end

    sep_d = win_open ? sep_q - SEP_W'(1) : '0;
    if (restart) sep_d = SEP_W'(T_SEP - 1);

    prev_d      = in_pulse;
    ts_d        = ts_q + CNT_W'(1);
    last_time_d = (k != '0) ? ts_q : last_time_q;
    viol_d      = is_viol;
    viol_src_d  = is_viol ? ev : viol_src_q;
    viol_cnt_d  = (is_viol && viol_cnt_q != '1) ? viol_cnt_q + CNT_W'(1) : viol_cnt_q;

    dl_d[0] = '{vld: ins_v, err: ins_e};
    for (int i = 1; i < DELAY; i++) dl_d[i] = dl_q[i-1];

    // A fresh arrival reloads the full width, so overlapping pulses merge.
    str_v_d = (str_v_q != '0) ? str_v_q - STR_W'(1) : '0;
    str_e_d = (str_e_q != '0) ? str_e_q - STR_W'(1) : '0;
    if (dl_q[DELAY-1].vld) str_v_d = STR_W'(PULSE_W);
    if (dl_q[DELAY-1].err) str_e_d = STR_W'(PULSE_W);
  end

  // State registers; the edge detector resets high so a held input is no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '1;
      ts_q        <= '0;
      last_time_q <= '0;
      sep_q       <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      viol_q      <= 1'b0;
      viol_src_q  <= '0;
      viol_cnt_q  <= '0;
      dl_q        <= '0;
      str_v_q     <= '0;
      str_e_q     <= '0;
    end else begin
      prev_q      <= prev_d;
      ts_q        <= ts_d;
      last_time_q <= last_time_d;
      sep_q       <= sep_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      viol_q      <= viol_d;
      viol_src_q  <= viol_src_d;
      viol_cnt_q  <= viol_cnt_d;
      dl_q        <= dl_d;
      str_v_q     <= str_v_d;
      str_e_q     <= str_e_d;
    end
  end

  assign out       = (str_v_q != '0);
  assign out_err   = (str_e_q != '0);
  assign viol      = viol_q;
  assign viol_src  = viol_src_q;
  assign viol_cnt  = viol_cnt_q;
  assign last_time = last_time_q;
  assign pend_cnt  = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_conf_merge_n.sv
// Bench for conf_merge_n: one flag-mode instance (defaults) and one queue-mode
// instance (N_IN=4). Stimulus pushes expected pulse/strobe cycles into
// queues; a monitor pops and compares as the DUT outputs appear.
module tb_conf_merge_n;

  localparam int PULSE_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   checks = 0;
  int   failures = 0;

  logic [1:0]  f_in = '0;
  logic        f_out, f_err, f_viol, f_ovf;
  logic [1:0]  f_src;
  logic [15:0] f_vcnt, f_last;
  logic [2:0]  f_pend;

  logic [3:0]  q_in = '0;
  logic        q_out, q_err, q_viol, q_ovf;
  logic [3:0]  q_src;
  logic [15:0] q_vcnt, q_last;
  logic [2:0]  q_pend;

  conf_merge_n u_f (
    .clk(clk), .rst_n(rst_n), .in_pulse(f_in), .out(f_out), .out_err(f_err),
    .viol(f_viol), .viol_src(f_src), .viol_cnt(f_vcnt), .last_time(f_last),
    .pend_cnt(f_pend), .ovf(f_ovf)
  );

  conf_merge_n #(.N_IN(4), .MODE(1)) u_q (
    .clk(clk), .rst_n(rst_n), .in_pulse(q_in), .out(q_out), .out_err(q_err),
    .viol(q_viol), .viol_src(q_src), .viol_cnt(q_vcnt), .last_time(q_last),
    .pend_cnt(q_pend), .ovf(q_ovf)
  );

  always #5 clk = ~clk;

  // Cycle index aligned with the DUT timestamp: value before edge n is n.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {int c; int src; int cnt;} ve_t;
  int  f_out_q[$], f_err_q[$], q_out_q[$];
  ve_t f_viol_q[$], q_viol_q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input int c);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, c);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: checks rise cycles, pulse widths and violation strobes.
  initial begin
    int  c;
    ve_t v;
    logic fo_p, fe_p, qo_p;
    int  fo_w, fe_w, qo_w;
    fo_p = 0; fe_p = 0; qo_p = 0; fo_w = 0; fe_w = 0; qo_w = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fo_p = 0; fe_p = 0; qo_p = 0; fo_w = 0; fe_w = 0; qo_w = 0;
      end else begin
        c = cyc - 1;
        if (f_out && !fo_p) begin
          if (f_out_q.size() != 0) chk("f_out_rise", c, f_out_q.pop_front());
          else unexp("f_out_rise", c);
        end
        if (f_err && !fe_p) begin
          if (f_err_q.size() != 0) chk("f_err_rise", c, f_err_q.pop_front());
          else unexp("f_err_rise", c);
        end
        if (q_out && !qo_p) begin
          if (q_out_q.size() != 0) chk("q_out_rise", c, q_out_q.pop_front());
          else unexp("q_out_rise", c);
        end
        if (f_out) fo_w++; else if (fo_p) begin chk("f_out_width", fo_w, PULSE_W); fo_w = 0; end
        if (f_err) fe_w++; else if (fe_p) begin chk("f_err_width", fe_w, PULSE_W); fe_w = 0; end
        if (q_out) qo_w++; else if (qo_p) begin chk("q_out_width", qo_w, PULSE_W); qo_w = 0; end
        if (f_viol) begin
          if (f_viol_q.size() != 0) begin
            v = f_viol_q.pop_front();
            chk("f_viol_cyc", c, v.c);
            chk("f_viol_src", f_src, v.src);
            chk("f_viol_cnt", f_vcnt, v.cnt);
          end else unexp("f_viol", c);
        end
        if (q_viol) begin
          if (q_viol_q.size() != 0) begin
            v = q_viol_q.pop_front();
            chk("q_viol_cyc", c, v.c);
            chk("q_viol_src", q_src, v.src);
            chk("q_viol_cnt", q_vcnt, v.cnt);
          end else unexp("q_viol", c);
        end
        if (q_err) unexp("q_out_err", c);
        fo_p = f_out; fe_p = f_err; qo_p = q_out;
      end
    end
  end

  // Stimulus: directed events with hand-computed expected responses.
  initial begin
    #1;
    chk("rst_f_out", f_out, 0);     chk("rst_f_err", f_err, 0);
    chk("rst_f_viol", f_viol, 0);   chk("rst_f_last", f_last, 0);
    chk("rst_q_pend", q_pend, 0);   chk("rst_q_ovf", q_ovf, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Queue mode: four simultaneous events re-spaced one window apart.
    wait_cyc(50);  q_in = 4'hF; q_out_q.push_back(65); q_out_q.push_back(75);
                   q_out_q.push_back(85); q_out_q.push_back(95);
    wait_cyc(51);  chk("q_pend_after50", q_pend, 3); chk("q_last_50", q_last, 50);
    wait_cyc(52);  q_in = 4'h0;
    wait_cyc(61);  chk("q_pend_after60", q_pend, 2);
    wait_cyc(81);  chk("q_pend_after80", q_pend, 0); chk("q_ovf_none", q_ovf, 0);

    // Flag mode: clean event, then a second input inside the window.
    wait_cyc(100); f_in = 2'b01; f_out_q.push_back(115);
    wait_cyc(101); chk("f_last_100", f_last, 100); chk("f_vcnt_0", f_vcnt, 0);
    wait_cyc(103); f_in = 2'b00;
    wait_cyc(105); f_in = 2'b10; f_viol_q.push_back('{105, 2, 1}); f_err_q.push_back(120);
    wait_cyc(106); chk("f_last_105", f_last, 105);
    wait_cyc(107); f_in = 2'b00;
    wait_cyc(108); chk("f_src_held", f_src, 2); chk("f_pend_zero", f_pend, 0);

    // Flag mode: simultaneous events are a violation even with window closed.
    wait_cyc(200); f_in = 2'b11; f_viol_q.push_back('{200, 3, 2}); f_err_q.push_back(215);
    wait_cyc(203); f_in = 2'b00;

    // Window boundary: T_SEP-1 after is a violation, exactly T_SEP is clean.
    wait_cyc(220); f_in = 2'b01; f_out_q.push_back(235);
    wait_cyc(222); f_in = 2'b00;
    wait_cyc(229); f_in = 2'b10; f_viol_q.push_back('{229, 2, 3}); f_err_q.push_back(244);
    wait_cyc(231); f_in = 2'b00;
    wait_cyc(239); f_in = 2'b01; f_out_q.push_back(254);
    wait_cyc(240); chk("f_vcnt_3", f_vcnt, 3); chk("f_last_239", f_last, 239);
    wait_cyc(241); f_in = 2'b00;

    // Queue mode overflow: six events in three cycles against DEPTH=4.
    wait_cyc(300); q_in = 4'b0011; q_out_q.push_back(315);
    wait_cyc(301); q_in = 4'b1100;
    wait_cyc(302); q_in = 4'b1111; q_viol_q.push_back('{302, 3, 1});
                   q_out_q.push_back(325); q_out_q.push_back(335);
                   q_out_q.push_back(345); q_out_q.push_back(355);
                   chk("q_pend_after301", q_pend, 3);
    wait_cyc(303); chk("q_pend_sat", q_pend, 4); chk("q_ovf_set", q_ovf, 1);
                   chk("q_last_302", q_last, 302);
    wait_cyc(304); q_in = 4'h0;
    wait_cyc(356); chk("q_pend_drained", q_pend, 0); chk("q_ovf_sticky", q_ovf, 1);

    // Reset with a pulse in flight and an input held high through release.
    wait_cyc(400); f_in = 2'b01;
    wait_cyc(410); rst_n = 1'b0;
    #1;
    chk("mid_rst_f_out", f_out, 0);   chk("mid_rst_f_vcnt", f_vcnt, 0);
    chk("mid_rst_f_last", f_last, 0); chk("mid_rst_f_src", f_src, 0);
    chk("mid_rst_q_ovf", q_ovf, 0);   chk("mid_rst_q_vcnt", q_vcnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(40);
    chk("post_rst_f_last", f_last, 0); chk("post_rst_f_vcnt", f_vcnt, 0);
    chk("post_rst_f_out", f_out, 0);

    chk("left_f_out", f_out_q.size(), 0);
    chk("left_f_err", f_err_q.size(), 0);
    chk("left_q_out", q_out_q.size(), 0);
    chk("left_f_viol", f_viol_q.size(), 0);
    chk("left_q_viol", q_viol_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
